// File: rtl/chargen_fifo.sv
`timescale 1ns/1ps
// chargen_fifo
//   First-word-fall-through character FIFO that sits directly behind chargen.
//   Both handshakes are active-low. wr_ready_n is withdrawn one entry early
//   (at DEPTH-1) so that a producer with one cycle of ready-to-valid latency
//   can land its last in-flight word in the remaining skid slot. Any write
//   attempted while full without a simultaneous pop is dropped and recorded
//   in the sticky overflow flag.
//
// Ports
//   clk         : clock, all state on rising edge
//   rst         : asynchronous active-high reset
//   wr_data     : producer data
//   wr_valid_n  : producer data valid (active-low)
//   wr_ready_n  : FIFO can accept (active-low, registered)
//   rd_data     : head-of-queue data (valid while rd_valid_n = 0)
//   rd_valid_n  : head data valid (active-low)
//   rd_ready_n  : consumer takes head (active-low)
//   count       : number of stored entries, 0..DEPTH
//   overflow    : sticky, set when a write is dropped
module chargen_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_valid_n,
  output logic                       wr_ready_n,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid_n,
  input  logic                       rd_ready_n,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_ready_n_q, wr_ready_n_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic push_try;
  logic push;
  logic pop;

  always_comb begin
    push_try = ~wr_valid_n;
    pop      = (count_q != '0) & ~rd_ready_n;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    push     = push_try & ((count_q < CW'(DEPTH)) | pop);

    wptr_d       = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d       = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);
    // Ready drops one slot early to leave room for the producer's skid word.
    wr_ready_n_d = (count_d >= CW'(DEPTH - 1));
    overflow_d   = overflow_q | (push_try & ~push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      wr_ready_n_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      wr_ready_n_q <= wr_ready_n_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage is deliberately not reset; only the pointers/count define contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign rd_data    = mem_q[rptr_q];
  assign rd_valid_n = (count_q == '0);
  assign wr_ready_n = wr_ready_n_q;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_chargen_fifo.sv
`timescale 1ns/1ps
module tb_chargen_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] wr_data;
  logic             wr_valid_n;
  logic             wr_ready_n;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid_n;
  logic             rd_ready_n;
  logic [2:0]       count;
  logic             overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a plain queue plus the two flags.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  bit               m_rdy_n;

  chargen_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_valid_n (wr_valid_n),
    .wr_ready_n (wr_ready_n),
    .rd_data    (rd_data),
    .rd_valid_n (rd_valid_n),
    .rd_ready_n (rd_ready_n),
    .count      (count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".rd_valid_n"}, 32'(rd_valid_n), 32'(mq.size() == 0));
    chk({tag, ".wr_ready_n"}, 32'(wr_ready_n), 32'(m_rdy_n));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
  endtask

  // One clock edge with the currently driven inputs, then model update and check.
  task automatic step(input string tag);
    bit               do_pop, try_push;
    logic [WIDTH-1:0] d;
    do_pop   = (mq.size() != 0) && !rd_ready_n;
    try_push = !wr_valid_n;
    d        = wr_data;
    @(posedge clk);
    #1;
    if (try_push && (mq.size() < DEPTH || do_pop)) begin
      if (do_pop) void'(mq.pop_front());
      mq.push_back(d);
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (try_push) m_ovf = 1'b1;
    end
    m_rdy_n = (mq.size() >= DEPTH - 1);
    chk_model(tag);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_rdy_n = 1'b1;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".rd_valid_n"}, 32'(rd_valid_n), 1);
    chk({tag, ".wr_ready_n"}, 32'(wr_ready_n), 1);
    chk({tag, ".overflow"}, 32'(overflow), 0);
    #1 rst = 1'b0;
    step({tag, ".release"});
    chk({tag, ".ready_after_release"}, 32'(wr_ready_n), 0);
  endtask

  initial begin
    string            exp_s;
    logic [WIDTH-1:0] ch;
    logic             rdy_b, vn_b;
    logic [WIDTH-1:0] exp_w [8];

    rst        = 1'b1;
    wr_data    = '0;
    wr_valid_n = 1'b1;
    rd_ready_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.count", 32'(count), 0);
    chk("rst.rd_valid_n", 32'(rd_valid_n), 1);
    chk("rst.wr_ready_n", 32'(wr_ready_n), 1);
    chk("rst.overflow", 32'(overflow), 0);
    rst = 1'b0;
    step("rel");
    chk("rel.wr_ready_n", 32'(wr_ready_n), 0);

    // FWFT from empty
    wr_data = "a"; wr_valid_n = 1'b0;
    step("fwft");
    chk("fwft.rd_valid_n", 32'(rd_valid_n), 0);
    chk("fwft.rd_data", 32'(rd_data), 32'("a"));
    chk("fwft.count", 32'(count), 1);
    wr_valid_n = 1'b1; rd_ready_n = 1'b0;
    step("fwft.pop");
    rd_ready_n = 1'b1;

    // chargen-like producer: valid_n follows ready_n one cycle late, 'a'..'c'
    ch = "a";
    for (int i = 0; i < 8; i++) begin
      rdy_b = wr_ready_n;
      vn_b  = wr_valid_n;
      step("gen");
      if (!vn_b) ch = (ch == "c") ? "a" : ch + 8'd1;
      wr_valid_n = rdy_b;
      wr_data    = ch;
    end
    chk("gen.count", 32'(count), 4);
    chk("gen.overflow", 32'(overflow), 0);
    chk("gen.valid_n_idle", 32'(wr_valid_n), 1);

    // Drain
    exp_s = "abca";
    rd_ready_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain.rd_data", 32'(rd_data), 32'(exp_s[i]));
      step("drain");
    end
    rd_ready_n = 1'b1;
    chk("drain.rd_valid_n", 32'(rd_valid_n), 1);
    chk("drain.count", 32'(count), 0);

    // Overflow while full
    wr_valid_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h30 + 8'(i);
      step("ovf.fill");
    end
    wr_valid_n = 1'b1;
    chk("ovf.count", 32'(count), 4);
    chk("ovf.flag", 32'(overflow), 1);
    rd_ready_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ovf.rd_data", 32'(rd_data), 32'(8'h30 + 8'(i)));
      step("ovf.drain");
    end
    rd_ready_n = 1'b1;
    chk("ovf.sticky", 32'(overflow), 1);

    // Async reset mid-stream (3 entries held)
    wr_valid_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'h50 + 8'(i);
      step("mid.fill");
    end
    wr_valid_n = 1'b1;
    chk("mid.count", 32'(count), 3);
    async_reset("mid.rst");

    // Full push+pop across pointer wrap
    wr_valid_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'hA0 + 8'(i);
      step("wrap.fill");
    end
    for (int i = 0; i < 4; i++) exp_w[i] = 8'hA0 + 8'(i);
    for (int i = 4; i < 8; i++) exp_w[i] = 8'h10 + 8'(i - 4);
    rd_ready_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_data = 8'h10 + 8'(i);
      chk("wrap.rd_data", 32'(rd_data), 32'(exp_w[i]));
      step("wrap");
    end
    chk("wrap.count", 32'(count), 4);
    chk("wrap.overflow", 32'(overflow), 0);
    wr_valid_n = 1'b1;
    for (int i = 0; i < 4; i++) step("wrap.drain");
    rd_ready_n = 1'b1;

    // Randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      wr_valid_n = ($urandom_range(0, 99) < 55) ? 1'b0 : 1'b1;
      rd_ready_n = ($urandom_range(0, 99) < 45) ? 1'b0 : 1'b1;
      wr_data    = 8'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
